cvita_rr_arbiter: RTL and testbench
===================================

Name: cvita_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_INPUTS CVITA streams onto one output stream.
- The output feeds a SID destination-lookup stage, and from there the crossbar.
- Whole packets are never interleaved.
- Inputs are enabled or disabled through the standard settings bus.
- The grant index is exported so downstream logic can tag the source port.

Parameters:
- NUM_INPUTS, 4, number of CVITA input streams (2..16).
- SRC_WIDTH, 2, width of o_tsrc; must equal clog2(NUM_INPUTS).
- SR_BASE, 0, settings-bus address of the enable-mask register.
- MASK_RESET, all ones, reset value of the enable mask (NUM_INPUTS bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data; bits [NUM_INPUTS-1:0] are the enable mask
- i_tdata  in  64*NUM_INPUTS  input data; port k occupies bits [64k+63:64k]
- i_tlast  in  NUM_INPUTS  per-port end of packet
- i_tvalid  in  NUM_INPUTS  per-port valid
- i_tready  out  NUM_INPUTS  per-port ready
- o_tdata  out  64  merged data
- o_tlast  out  1  merged end of packet
- o_tvalid  out  1  merged valid
- o_tready  in  1  downstream ready
- o_tsrc  out  SRC_WIDTH  index of the granted port, valid with o_tdata
- pkt_count  out  32  count of packets forwarded; wraps

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - state = IDLE, grant = 0, last_grant = NUM_INPUTS-1 (so port 0 is checked first).
  - mask = MASK_RESET, pkt_count = 0.
  - o_tvalid = 0, i_tready = all 0, o_tsrc = 0.
- Settings:
  - When set_stb = 1 and set_addr == SR_BASE, mask <= set_data[NUM_INPUTS-1:0] on the next edge.
  - Other addresses are ignored.
- State IDLE:
  - o_tvalid = 0 and all i_tready = 0.
  - req = i_tvalid & mask.
  - If req != 0: grant <= the first k with req[k] = 1, scanning last_grant+1, last_grant+2, ... modulo NUM_INPUTS. Then state <= PASS.
  - If req == 0: stay in IDLE.
- State PASS:
  - o_tdata = i_tdata[grant], o_tlast = i_tlast[grant], o_tvalid = i_tvalid[grant], o_tsrc = grant.
  - i_tready[grant] = o_tready; all other i_tready = 0.
  - The output path is combinational from the granted port: no added data latency and no buffering.
  - On o_tvalid & o_tready & o_tlast: last_grant <= grant, pkt_count <= pkt_count + 1 (mod 2^32), state <= IDLE.
- Latency:
  - Exactly one arbitration cycle between a request being seen in IDLE and o_tvalid being asserted.
  - There is therefore one idle bubble between back-to-back packets.
  - Minimum output occupancy is L+1 cycles per L-beat packet.
- Fairness: with all ports continuously requesting, grants cycle 0,1,...,N-1,0,... One packet per grant.
- Mask changes:
  - A mask change during PASS does not affect the packet in flight; that packet completes.
  - A port disabled while granted is still drained to tlast.
  - The new mask applies at the next IDLE evaluation.
- A port whose i_tvalid drops mid-packet keeps the grant; the arbiter waits indefinitely. There is no timeout.
- A single-beat packet (tlast on the first beat) is legal: one beat in PASS, then back to IDLE.
- If mask = 0, the arbiter stays in IDLE permanently and all i_tready = 0.
- Reset asserted mid-packet: the arbiter returns immediately to IDLE and the partial packet is truncated. Upstream is responsible for flushing.
- Inputs must present valid CVITA framing; the arbiter only uses tlast.

Test Plan:
1. Reset, then port 2 sends a 3-beat packet (data 0xA0, 0xA1, 0xA2), o_tready = 1 → o_tvalid rises 1 cycle after i_tvalid[2]; o_tsrc = 2; 3 output beats; pkt_count = 1.
2. All 4 ports continuously present 2-beat packets → grant order 0,1,2,3,0,1; no beat interleaving; pkt_count = 6 after 18 cycles.
3. Write mask 4'b0101 via set_stb at SR_BASE, all ports requesting → only ports 0 and 2 are granted, alternating; i_tready[1] and i_tready[3] stay 0.
4. Port 1 is granted a 4-beat packet; during beat 2, write mask 4'b0001 → the port 1 packet completes all 4 beats; next grant goes to port 0.
5. o_tready toggles 1,0,1,0 during a 5-beat packet on port 3 → i_tready[3] mirrors o_tready; no beat is lost or duplicated; o_tlast appears on beat 5 only.
6. Assert rst_n = 0 mid-packet on port 0 → o_tvalid = 0 and i_tready = 0 immediately; after release, port 0 is the first candidate; pkt_count = 0.

Source files
------------

// File: rtl/cvita_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_INPUTS CVITA streams onto one output.
// Data path is combinational from the granted port; one arbitration cycle per packet.
module cvita_rr_arbiter #(
  parameter int unsigned            NUM_INPUTS = 4,
  parameter int unsigned            SRC_WIDTH  = 2,
  parameter logic [7:0]             SR_BASE    = 8'd0,
  parameter logic [NUM_INPUTS-1:0]  MASK_RESET = '1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_stb,
  input  logic [7:0]               set_addr,
  input  logic [31:0]              set_data,
  input  logic [64*NUM_INPUTS-1:0] i_tdata,
  input  logic [NUM_INPUTS-1:0]    i_tlast,
  input  logic [NUM_INPUTS-1:0]    i_tvalid,
  output logic [NUM_INPUTS-1:0]    i_tready,
  output logic [63:0]              o_tdata,
  output logic                     o_tlast,
  output logic                     o_tvalid,
  input  logic                     o_tready,
  output logic [SRC_WIDTH-1:0]     o_tsrc,
  output logic [31:0]              pkt_count
);

  typedef enum logic {IDLE, PASS} state_e;

  state_e                 state_q, state_d;
  logic [SRC_WIDTH-1:0]   grant_q, grant_d;
  logic [SRC_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [NUM_INPUTS-1:0]  mask_q, mask_d;
  logic [31:0]            pkt_count_q, pkt_count_d;
  logic [NUM_INPUTS-1:0]  req;
  logic [SRC_WIDTH-1:0]   pick, idx;
  logic                   found;
  logic                   set_data_unused;

  assign set_data_unused = ^set_data;
  assign req             = i_tvalid & mask_q;

  // First requester after last_grant, wrapping modulo NUM_INPUTS.
  always_comb begin
    pick  = last_grant_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= NUM_INPUTS; off++) begin
      idx = SRC_WIDTH'((32'(last_grant_q) + off) % NUM_INPUTS);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign o_tdata   = i_tdata[{grant_q, 6'd0} +: 64];
  assign o_tlast   = i_tlast[grant_q];
  assign o_tsrc    = grant_q;
  assign pkt_count = pkt_count_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_count_d  = pkt_count_q;
    mask_d       = mask_q;
    o_tvalid     = 1'b0;
    i_tready     = '0;

    if (set_stb && (set_addr == SR_BASE)) begin
      mask_d = set_data[NUM_INPUTS-1:0];
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = PASS;
        end
      end
      PASS: begin
        o_tvalid          = i_tvalid[grant_q];
        i_tready[grant_q] = o_tready;
        if (o_tvalid && o_tready && o_tlast) begin
          last_grant_d = grant_q;
          pkt_count_d  = pkt_count_q + 32'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SRC_WIDTH'(NUM_INPUTS - 1);
      mask_q       <= MASK_RESET;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mask_q       <= mask_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_cvita_rr_arbiter.sv
// Scoreboard bench for cvita_rr_arbiter: packet-level round-robin model predicts
// the merged beat stream; a separate monitor checks every output handshake.
module tb_cvita_rr_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            set_stb = 1'b0;
  logic [7:0]      set_addr = '0;
  logic [31:0]     set_data = '0;
  logic [64*N-1:0] i_tdata = '0;
  logic [N-1:0]    i_tlast = '0;
  logic [N-1:0]    i_tvalid = '0;
  logic [N-1:0]    i_tready;
  logic [63:0]     o_tdata;
  logic            o_tlast;
  logic            o_tvalid;
  logic            o_tready = 1'b1;
  logic [1:0]      o_tsrc;
  logic [31:0]     pkt_count;

  cvita_rr_arbiter #(.NUM_INPUTS(4), .SRC_WIDTH(2), .SR_BASE(8'd0), .MASK_RESET(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tsrc(o_tsrc), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic last; logic first; } beat_t;
  typedef struct { logic [63:0] data; logic last; logic [1:0] src; } exp_t;

  beat_t        src_q [N][$];
  exp_t         exp_q [$];
  logic [N-1:0] fired = '0;
  logic [N-1:0] chk_mask = '1;
  int           rdy_mode = 0;
  bit           gap_en = 1'b0;
  int           model_last = N - 1;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int k, input int len, input logic [63:0] base);
    for (int b = 0; b < len; b++)
      src_q[k].push_back('{data: base + 64'(b), last: (b == len - 1), first: (b == 0)});
  endtask

  // Packet-level round robin over the loaded source queues.
  task automatic plan(input logic [N-1:0] m);
    int pos [N];
    for (int k = 0; k < N; k++) pos[k] = 0;
    while (1) begin
      int sel;
      bit done;
      sel = -1;
      for (int off = 1; off <= N; off++) begin
        int k;
        k = (model_last + off) % N;
        if (sel < 0 && m[k] && pos[k] < src_q[k].size()) sel = k;
      end
      if (sel < 0) break;
      done = 1'b0;
      while (!done) begin
        beat_t b;
        b = src_q[sel][pos[sel]];
        pos[sel]++;
        exp_q.push_back('{data: b.data, last: b.last, src: 2'(sel)});
        done = b.last;
      end
      model_last = sel;
    end
  endtask

  // Source driver: valid held until accepted; gaps only inside a packet.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (fired[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          i_tvalid[k] = !(gap_en && !src_q[k][0].first && $urandom_range(0, 3) == 0);
          i_tdata[k*64 +: 64] = src_q[k][0].data;
          i_tlast[k] = src_q[k][0].last;
        end else begin
          i_tvalid[k] = 1'b0;
          i_tlast[k]  = 1'b0;
        end
      end
      case (rdy_mode)
        0: o_tready = 1'b1;
        1: o_tready = ($urandom_range(0, 2) != 0);
        default: o_tready = ~o_tready;
      endcase
      #4;
      fired = i_tvalid & i_tready & {N{rst_n}};
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t         e;
    logic [N-1:0] r;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && o_tvalid) begin
        r = '0;
        r[o_tsrc] = o_tready;
        check("ready_onehot", 64'(i_tready), 64'(r));
        check("ready_mask", 64'(i_tready & ~chk_mask), 64'd0);
        if (o_tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got src %0d data %0h expected no beat", o_tsrc, o_tdata);
          end else begin
            e = exp_q.pop_front();
            check("tdata", o_tdata, e.data);
            check("tlast", 64'(o_tlast), 64'(e.last));
            check("tsrc", 64'(o_tsrc), 64'(e.src));
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_tready", 64'(i_tready), 64'd0);
    check("rst_tsrc", 64'(o_tsrc), 64'd0);
    check("rst_count", 64'(pkt_count), 64'd0);
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    fired = '0;
    rdy_mode = 0;
    gap_en = 1'b0;
    chk_mask = '1;
    model_last = N - 1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic sb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    set_stb = 1'b1;
    set_addr = a;
    set_data = d;
    @(negedge clk);
    set_stb = 1'b0;
    #1;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_grant(input string name, input logic [1:0] port);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #4;
      if (o_tvalid && o_tsrc == port) break;
    end
    check(name, 64'(o_tvalid && o_tsrc == port), 64'd1);
  endtask

  initial begin
    int total;

    // 1: single 3-beat packet on port 2, one arbitration cycle
    do_reset();
    add_pkt(2, 3, 64'hA0);
    plan(4'hF);
    @(negedge clk); #4;
    check("t1_arb_cycle_tvalid", 64'(o_tvalid), 64'd0);
    @(negedge clk); #4;
    check("t1_first_tvalid", 64'(o_tvalid), 64'd1);
    check("t1_first_tsrc", 64'(o_tsrc), 64'd2);
    wait_empty("t1_drain");
    check("t1_count", 64'(pkt_count), 64'd1);

    // 2: all ports requesting, 2-beat packets: 0,1,2,3,0,1 with one bubble each
    do_reset();
    for (int p = 0; p < 2; p++) begin
      add_pkt(0, 2, 64'h0100 + 64'(p * 16));
      add_pkt(1, 2, 64'h1100 + 64'(p * 16));
    end
    add_pkt(2, 2, 64'h2100);
    add_pkt(3, 2, 64'h3100);
    plan(4'hF);
    repeat (18) @(negedge clk);
    #4;
    check("t2_count_17", 64'(pkt_count), 64'd5);
    @(negedge clk); #4;
    check("t2_count_18", 64'(pkt_count), 64'd6);
    wait_empty("t2_drain");

    // 3: mask 0101, only ports 0 and 2 alternate
    do_reset();
    sb_write(8'd0, 32'h5);
    chk_mask = 4'b0101;
    for (int k = 0; k < N; k++)
      for (int p = 0; p < 2; p++) add_pkt(k, 2, 64'(k * 256 + p * 16));
    plan(4'b0101);
    wait_empty("t3_drain");
    repeat (4) @(negedge clk);
    #4;
    check("t3_masked_idle", 64'(o_tvalid), 64'd0);
    check("t3_masked_tready", 64'(i_tready), 64'd0);
    check("t3_count", 64'(pkt_count), 64'd4);

    // 4: mask narrowed to port 0 during beat 2 of a port-1 packet
    do_reset();
    add_pkt(1, 4, 64'h4100);
    plan(4'hF);
    wait_grant("t4_grant1", 2'd1);
    add_pkt(0, 2, 64'h4000);
    add_pkt(2, 2, 64'h4200);
    plan(4'b0001);
    sb_write(8'd0, 32'h1);
    wait_empty("t4_drain");
    repeat (5) @(negedge clk);
    #4;
    check("t4_no_port2", 64'(o_tvalid), 64'd0);
    check("t4_count", 64'(pkt_count), 64'd2);

    // 5: toggling o_tready over a 5-beat packet on port 3
    do_reset();
    rdy_mode = 2;
    add_pkt(3, 5, 64'h5300);
    plan(4'hF);
    wait_empty("t5_drain");
    check("t5_count", 64'(pkt_count), 64'd1);

    // 6: reset mid-packet truncates; port 0 is first candidate afterwards
    do_reset();
    add_pkt(0, 4, 64'h6000);
    plan(4'hF);
    wait_grant("t6_grant0", 2'd0);
    do_reset();
    add_pkt(1, 2, 64'h6100);
    add_pkt(0, 2, 64'h6010);
    plan(4'hF);
    check("t6_count_after", 64'(pkt_count), 64'd0);
    wait_empty("t6_drain");
    check("t6_count", 64'(pkt_count), 64'd2);

    // 7: random packets, gaps and backpressure; foreign settings address ignored
    for (int round = 0; round < 4; round++) begin
      do_reset();
      rdy_mode = 1;
      gap_en = 1'b1;
      total = 0;
      for (int k = 0; k < N; k++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          add_pkt(k, $urandom_range(1, 5), {$urandom, $urandom});
          total++;
        end
      end
      plan(4'hF);
      repeat (6) @(negedge clk);
      sb_write(8'd1, 32'h0);
      wait_empty("t7_drain");
      check("t7_count", 64'(pkt_count), 64'(total));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
